// File: rtl/dist_pkg.sv
// Shared constants for the 1-to-4 data distributor: channel count, select codes
// and the width helper used to size the FIFO pointers and occupancy counters.
package dist_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  localparam logic [CH_W-1:0] CH0 = 2'b00;
  localparam logic [CH_W-1:0] CH1 = 2'b01;
  localparam logic [CH_W-1:0] CH2 = 2'b10;
  localparam logic [CH_W-1:0] CH3 = 2'b11;

  // Number of bits needed to index n entries (ceil(log2(n))).
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dist_fifo.sv
// Per-channel FIFO: register array with read/write pointers and an occupancy
// counter. The head word is presented on DOUT with no bypass from DIN.
module dist_fifo
  import dist_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = 2
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         PUSH,
  input  logic [W-1:0] DIN,
  input  logic         POP,
  output logic [W-1:0] DOUT,
  output logic         FULL,
  output logic         EMPTY
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH) + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign FULL    = (count_q == CNT_W'(DEPTH));
  assign EMPTY   = (count_q == '0);
  assign DOUT    = mem_q[rd_ptr_q];
  assign do_push = PUSH & ~FULL;
  assign do_pop  = POP & ~EMPTY;

  // NOTE: every always_comb output gets its default first, so no path leaves
  // a signal unassigned and no latch is inferred; blocking '=' is correct here.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = DIN;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // NOTE: state registers use non-blocking '<=' so all flops update together.
  // The storage array is reset as well, so no stale word survives a reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/data_distributor.sv
// 1-to-4 data distributor: one valid/ready input steered by S into four
// independently drained channel FIFOs.
module data_distributor
  import dist_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic [CH_W-1:0]   S,
  input  logic [W-1:0]      DIN,
  input  logic              IN_VLD,
  output logic              IN_RDY,
  output logic [W-1:0]      Y0,
  output logic [W-1:0]      Y1,
  output logic [W-1:0]      Y2,
  output logic [W-1:0]      Y3,
  output logic [NUM_CH-1:0] VLD,
  input  logic [NUM_CH-1:0] RDY
);

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] vld;
  logic [W-1:0]      dout [NUM_CH];
  logic              accept;

  // Ready depends only on enable, select and FIFO state, never on RDY.
  assign IN_RDY = RST_N & ~EN & ~full[S];
  assign accept = IN_VLD & IN_RDY;

  always_comb begin
    push = '0;
    if (accept) begin
      case (S)
        CH0:     push = 4'b0001;
        CH1:     push = 4'b0010;
        CH2:     push = 4'b0100;
        CH3:     push = 4'b1000;
        default: push = '0;
      endcase
    end
  end

  assign vld = ~empty;
  assign pop = vld & RDY;
  assign VLD = vld;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    dist_fifo #(
      .W    (W),
      .DEPTH(DEPTH)
    ) u_fifo (
      .CLK  (CLK),
      .RST_N(RST_N),
      .PUSH (push[i]),
      .DIN  (DIN),
      .POP  (pop[i]),
      .DOUT (dout[i]),
      .FULL (full[i]),
      .EMPTY(empty[i])
    );
  end

  // Outputs read as zero whenever their channel holds nothing.
  assign Y0 = vld[0] ? dout[0] : '0;
  assign Y1 = vld[1] ? dout[1] : '0;
  assign Y2 = vld[2] ? dout[2] : '0;
  assign Y3 = vld[3] ? dout[3] : '0;

endmodule

// File: tb/tb_data_distributor.sv
// Self-checking bench for data_distributor: directed vector table, hand-written
// corner sequences and a random run against four per-channel reference queues.
module tb_data_distributor;

  localparam int W      = 2;
  localparam int DEPTH  = 2;
  localparam int NUM_CH = 4;

  logic              CLK;
  logic              RST_N;
  logic              EN;
  logic [1:0]        S;
  logic [W-1:0]      DIN;
  logic              IN_VLD;
  logic              IN_RDY;
  logic [W-1:0]      Y0, Y1, Y2, Y3;
  logic [NUM_CH-1:0] VLD;
  logic [NUM_CH-1:0] RDY;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]   s;
    logic [W-1:0] din;
    logic [3:0]   exp_vld;
  } route_vec_t;

  route_vec_t   rv [4];
  logic [W-1:0] mq [NUM_CH][$];

  data_distributor #(.W(W), .DEPTH(DEPTH)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .EN    (EN),
    .S     (S),
    .DIN   (DIN),
    .IN_VLD(IN_VLD),
    .IN_RDY(IN_RDY),
    .Y0    (Y0),
    .Y1    (Y1),
    .Y2    (Y2),
    .Y3    (Y3),
    .VLD   (VLD),
    .RDY   (RDY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] y_of(input int ch);
    case (ch)
      0:       return Y0;
      1:       return Y1;
      2:       return Y2;
      default: return Y3;
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [1:0] s, input logic [W-1:0] d, input string nm);
    S      = s;
    DIN    = d;
    IN_VLD = 1'b1;
    #1;
    check(nm, 32'(IN_RDY), 32'd1);
    tick();
    IN_VLD = 1'b0;
  endtask

  task automatic drain();
    IN_VLD = 1'b0;
    RDY    = 4'hF;
    repeat (DEPTH) tick();
    RDY = 4'h0;
    #1;
    check("drain_empty", 32'(VLD), 32'h0);
  endtask

  initial begin
    logic         exp_rdy;
    logic         s_en, s_vld;
    logic [1:0]   s_s;
    logic [W-1:0] s_din;
    logic [3:0]   s_rdy;

    rv[0] = '{s: 2'b00, din: 2'b01, exp_vld: 4'b0001};
    rv[1] = '{s: 2'b01, din: 2'b10, exp_vld: 4'b0011};
    rv[2] = '{s: 2'b10, din: 2'b11, exp_vld: 4'b0111};
    rv[3] = '{s: 2'b11, din: 2'b00, exp_vld: 4'b1111};

    RST_N  = 1'b0;
    EN     = 1'b0;
    S      = 2'b00;
    DIN    = '0;
    IN_VLD = 1'b0;
    RDY    = 4'h0;
    #1;
    check("reset_vld", 32'(VLD), 32'h0);
    check("reset_in_rdy", 32'(IN_RDY), 32'h0);
    check("reset_y0", 32'(Y0), 32'h0);
    tick();
    tick();
    RST_N = 1'b1;
    #1;
    check("post_reset_in_rdy", 32'(IN_RDY), 32'h1);

    // Routing through the vector table.
    for (int i = 0; i < 4; i++) begin
      push(rv[i].s, rv[i].din, $sformatf("route_in_rdy_%0d", i));
      check($sformatf("route_vld_%0d", i), 32'(VLD), 32'(rv[i].exp_vld));
      check($sformatf("route_y_%0d", i), 32'(y_of(int'(rv[i].s))), 32'(rv[i].din));
    end
    check("route_y0", 32'(Y0), 32'h1);
    check("route_y1", 32'(Y1), 32'h2);
    check("route_y2", 32'(Y2), 32'h3);
    check("route_y3", 32'(Y3), 32'h0);
    drain();

    // Full channel 2: third word held until a pop frees a slot.
    push(2'b10, 2'b01, "full_push0");
    push(2'b10, 2'b10, "full_push1");
    DIN    = 2'b11;
    IN_VLD = 1'b1;
    #1;
    check("full_in_rdy", 32'(IN_RDY), 32'h0);
    tick();
    check("full_held_in_rdy", 32'(IN_RDY), 32'h0);
    check("full_head_w0", 32'(Y2), 32'h1);
    RDY = 4'b0100;
    #1;
    check("full_pop_same_cycle_in_rdy", 32'(IN_RDY), 32'h0);
    tick();
    RDY = 4'h0;
    #1;
    check("full_after_pop_in_rdy", 32'(IN_RDY), 32'h1);
    check("full_order_w1", 32'(Y2), 32'h2);
    tick();
    IN_VLD = 1'b0;
    RDY    = 4'b0100;
    #1;
    check("full_order_w1_again", 32'(Y2), 32'h2);
    tick();
    check("full_order_w2", 32'(Y2), 32'h3);
    tick();
    check("full_drained", 32'(VLD[2]), 32'h0);
    RDY = 4'h0;

    // RDY on an empty channel is ignored; push+pop keeps occupancy at 1.
    RDY = 4'b0001;
    tick();
    check("empty_rdy_ignored", 32'(VLD[0]), 32'h0);
    RDY = 4'h0;
    push(2'b00, 2'b01, "sim_push0");
    check("sim_y0_first", 32'(Y0), 32'h1);
    RDY = 4'b0001;
    push(2'b00, 2'b10, "sim_push1");
    check("sim_y0_next", 32'(Y0), 32'h2);
    check("sim_vld0", 32'(VLD[0]), 32'h1);
    tick();
    check("sim_count_one", 32'(VLD[0]), 32'h0);
    RDY = 4'h0;

    // Enable high blocks input while ch3 drains.
    push(2'b11, 2'b10, "en_push0");
    push(2'b11, 2'b01, "en_push1");
    EN     = 1'b1;
    S      = 2'b11;
    DIN    = 2'b11;
    IN_VLD = 1'b1;
    #1;
    check("en_in_rdy_s3", 32'(IN_RDY), 32'h0);
    S = 2'b00;
    #1;
    check("en_in_rdy_s0", 32'(IN_RDY), 32'h0);
    RDY = 4'b1000;
    tick();
    check("en_drain_y3", 32'(Y3), 32'h1);
    check("en_drain_vld3", 32'(VLD[3]), 32'h1);
    tick();
    check("en_drained_vld", 32'(VLD), 32'h0);
    IN_VLD = 1'b0;
    EN     = 1'b0;
    RDY    = 4'h0;

    // Asynchronous reset mid-stream with two words in ch1.
    push(2'b01, 2'b11, "rst_push0");
    push(2'b01, 2'b10, "rst_push1");
    S = 2'b01;
    #1;
    check("rst_pre_vld1", 32'(VLD[1]), 32'h1);
    #2;
    RST_N = 1'b0;
    #1;
    check("rst_async_vld", 32'(VLD), 32'h0);
    check("rst_async_y1", 32'(Y1), 32'h0);
    check("rst_async_in_rdy", 32'(IN_RDY), 32'h0);
    tick();
    tick();
    RST_N = 1'b1;
    #1;
    check("rst_release_in_rdy", 32'(IN_RDY), 32'h1);
    tick();
    check("rst_ch1_empty", 32'(VLD[1]), 32'h0);

    // Random traffic against per-channel reference queues.
    for (int c = 0; c < 2000; c++) begin
      EN     = ($urandom_range(0, 3) == 0);
      S      = 2'($urandom_range(0, 3));
      DIN    = W'($urandom);
      IN_VLD = 1'($urandom);
      RDY    = 4'($urandom);
      #1;
      exp_rdy = !EN && (mq[S].size() < DEPTH);
      check("rnd_in_rdy", 32'(IN_RDY), 32'(exp_rdy));
      for (int ch = 0; ch < NUM_CH; ch++) begin
        check($sformatf("rnd_vld_%0d", ch), 32'(VLD[ch]), 32'(mq[ch].size() > 0));
        check($sformatf("rnd_y_%0d", ch), 32'(y_of(ch)),
              32'((mq[ch].size() > 0) ? mq[ch][0] : '0));
      end
      s_en  = EN;
      s_s   = S;
      s_din = DIN;
      s_vld = IN_VLD;
      s_rdy = RDY;
      @(posedge CLK);
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (s_rdy[ch] && mq[ch].size() > 0) void'(mq[ch].pop_front());
      end
      if (s_vld && !s_en && exp_rdy) mq[s_s].push_back(s_din);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
